period_channel_arbiter: RTL

- Shares one downstream measurement stream between NUM_CH period-measurement channels, e.g. pitch and volume antenna sensors.
- Each channel presents single-cycle edge strobes carrying a DURATION value. The block buffers them per channel and drains them round-robin through one valid/ready output port.
- Also applies per-channel enable configuration and keeps saturating drop counters.
- Sits between the per-antenna period measure units and the sample processing/CPU-side logic, all in the 200MHz CLK_PARALLEL domain.

---
 rtl/period_channel_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/period_channel_arbiter.sv
// period_channel_arbiter: per-channel FIFOs for period strobes, drained round-robin
// through one valid/ready output register, with saturating per-channel drop counters.
module period_channel_arbiter #(
    parameter int NUM_CH       = 2,
    parameter int COUNTER_BITS = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int OVF_BITS     = 8,
    localparam int CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           CLK_PARALLEL,
    input  logic                           RESET,
    input  logic [NUM_CH-1:0]              IN_VALID,
    input  logic [NUM_CH*COUNTER_BITS-1:0] IN_DURATION,
    input  logic [NUM_CH-1:0]              IN_ENABLE,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [CW-1:0]                  OUT_CHANNEL,
    output logic [COUNTER_BITS-1:0]        OUT_DURATION,
    input  logic                           OVERFLOW_CLEAR,
    output logic [NUM_CH*OVF_BITS-1:0]     OVERFLOW_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    typedef enum logic {S_EMPTY, S_LOADED} state_t;
    state_t state_q, state_d;
    logic [COUNTER_BITS-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0] wr_q [NUM_CH];
    logic [PW-1:0] rd_q [NUM_CH];
    logic [NUM_CH-1:0][OVF_BITS-1:0] ovf_q;
    logic [CW-1:0] rr_q, ch_q, gnt;
    logic [COUNTER_BITS-1:0] dur_q;
    logic [NUM_CH-1:0] empty, full, cand, push, pop, drop;
    logic found, load, grant;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = wr_q[c] == rd_q[c];
            full[c] = (wr_q[c] - rd_q[c]) == PW'(FIFO_DEPTH);
        end
        cand = IN_ENABLE & ~empty;
    end

    always_comb begin
        gnt = rr_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found && cand[(int'(rr_q) + k) % NUM_CH]) begin
                found = 1'b1;
                gnt = CW'((int'(rr_q) + k) % NUM_CH);
            end
        end
        load = (state_q == S_EMPTY) || OUT_READY;
        grant = load && found;
        pop = grant ? NUM_CH'(1) << gnt : '0;
        push = IN_VALID & IN_ENABLE & (~full | pop);
        drop = IN_VALID & IN_ENABLE & full & ~pop;
    end

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) state_q <= S_EMPTY;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = (grant || (state_q == S_LOADED && !OUT_READY)) ? S_LOADED : S_EMPTY;
    end

    always_comb begin
        OUT_VALID = state_q == S_LOADED;
        OUT_CHANNEL = ch_q;
        OUT_DURATION = dur_q;
        OVERFLOW_COUNT = ovf_q;
    end

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            rr_q <= CW'(NUM_CH - 1);
            ch_q <= '0;
            dur_q <= '0;
        end else if (grant) begin
            rr_q <= gnt;
            ch_q <= gnt;
            dur_q <= mem_q[gnt][rd_q[gnt][AW-1:0]];
        end
    end

    // A disabled channel is flushed every cycle rather than just gated.
    always_ff @(posedge CLK_PARALLEL) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (RESET || !IN_ENABLE[c]) begin
                wr_q[c] <= '0;
                rd_q[c] <= '0;
            end else begin
                if (push[c]) wr_q[c] <= wr_q[c] + PW'(1);
                if (pop[c]) rd_q[c] <= rd_q[c] + PW'(1);
            end
            if (push[c]) mem_q[c][wr_q[c][AW-1:0]] <= IN_DURATION[c*COUNTER_BITS +: COUNTER_BITS];
        end
    end

    always_ff @(posedge CLK_PARALLEL) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (RESET || OVERFLOW_CLEAR) ovf_q[c] <= '0;
            else if (drop[c] && !(&ovf_q[c])) ovf_q[c] <= ovf_q[c] + OVF_BITS'(1);
        end
    end
endmodule
